regfile_hilo: RTL and testbench
===============================

Name: regfile_hilo

Overview:
- Architectural state block at the far end of the WB-to-register-file interface.
- Holds 32x32 general-purpose registers (GPRs) plus the HI and LO registers.
- Commits the writes that WB drives, and serves two combinational GPR read ports plus HI/LO reads to ID.
- Resolves EX, MEM and WB forwarding on the read paths, so ID sees the newest value without a separate bypass unit.

Parameters:
- WB_TO_RF_WD, 38, width of the WB write bus: {we[37], waddr[36:32], wdata[31:0]}.
- NREG, 32, number of GPRs (fixed; r0 hardwired zero).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_to_rf_bus  in  38  WB commit: {we, waddr, wdata}.
- hilo_wb_to_rf_bus  in  2  WB HI/LO write enables {hi_we, lo_we}.
- wb_hi_wdata  in  32  HI write data.
- wb_lo_wdata  in  32  LO write data.
- ex_we  in  1  EX-stage pending GPR write, forwarding only.
- ex_waddr  in  5  EX destination.
- ex_wdata  in  32  EX result.
- mem_we  in  1  MEM-stage pending GPR write, forwarding only.
- mem_waddr  in  5  MEM destination.
- mem_wdata  in  32  MEM result.
- raddr1  in  5  read port 1 address.
- raddr2  in  5  read port 2 address.
- rdata1  out  32  read port 1 data, combinational.
- rdata2  out  32  read port 2 data, combinational.
- hi_rdata  out  32  HI value, combinational.
- lo_rdata  out  32  LO value, combinational.
- commit_cnt  out  32  count of committed non-r0 GPR writes.

Behaviour:
- Reset
  - rst=1 at posedge clears all GPRs, HI, LO and commit_cnt to 0.
  - rst overrides any write presented in the same cycle.
  - The first write takes effect at the first posedge with rst=0.
- GPR commit
  - At posedge with we=1 and waddr!=0: gpr[waddr] <= wdata, and commit_cnt increments by 1.
  - commit_cnt wraps 0xFFFFFFFF -> 0.
  - we=1 with waddr=0 is discarded; commit_cnt does not increment.
  - The block ignores stall. WB already injects a zero bubble on stall, so a zero bus means no write.
- HI/LO commit
  - hi_we=1: HI <= wb_hi_wdata. lo_we=1: LO <= wb_lo_wdata.
  - Both enables may be set in the same cycle, and each is independent.
- GPR read, per port, combinational, priority highest first:
  1. raddr==0 -> 0. This covers forwarded writes to r0, which never forward.
  2. ex_we && ex_waddr==raddr -> ex_wdata.
  3. mem_we && mem_waddr==raddr -> mem_wdata.
  4. WB we && waddr==raddr -> WB wdata (same-cycle write-through).
  5. Otherwise gpr[raddr].
- HI/LO read
  - hi_rdata = hi_we ? wb_hi_wdata : HI. LO behaves the same with lo_we.
  - Zero-cycle write-through, same as GPRs.
- During rst=1
  - Read ports still apply forwarding against the current inputs.
  - The array term reads stored contents, which are 0 after one reset cycle.
- Timing: no latency beyond the register. A write at edge N is visible from the array at edge N+1, and through bypass during cycle N.
- Both read ports addressing the same register return identical data.

Test Plan:
1. Hold rst for 2 cycles with we=1, waddr=5, wdata=0xDEADBEEF, then release.
   -> rdata1 for raddr1=5 is 0 (array term; WB bus is then idle), and commit_cnt=0.
2. Commit waddr=3, wdata=0x12345678 while raddr1=3 in the same cycle.
   -> rdata1=0x12345678 in that cycle (bypass) and after the edge (array); commit_cnt=1.
3. Write r0=0xFFFFFFFF from WB while ex_we=1 with ex_waddr=0.
   -> rdata1 for raddr1=0 is 0; commit_cnt is unchanged.
4. Address r7 from all sources: ex=0xA, mem=0xB, wb=0xC, array=0xD.
   -> reads 0xA. Drop ex_we -> 0xB. Drop mem_we -> 0xC.
5. Set hi_we=1 and lo_we=1 with HI=0x1, LO=0x2 data presented; next cycle only lo_we=1 with 0x3.
   -> first cycle hi_rdata=0x1, lo_rdata=0x2; next cycle hi_rdata=0x1 (held), lo_rdata=0x3.
6. Preload commit_cnt to 0xFFFFFFFF via 2^32-1 commits or a force, then commit one more write.
   -> commit_cnt=0.

Source files
------------

// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - GPR/HI/LO architectural state with EX/MEM/WB read forwarding
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb_to_rf_bus        WB commit {we, waddr[4:0], wdata[31:0]}
//   hilo_wb_to_rf_bus   WB HI/LO write enables {hi_we, lo_we}
//   wb_hi_wdata         HI write data
//   wb_lo_wdata         LO write data
//   ex_we/waddr/wdata   EX-stage pending write, forwarding only
//   mem_we/waddr/wdata  MEM-stage pending write, forwarding only
//   raddr1/2, rdata1/2  combinational GPR read ports
//   hi_rdata, lo_rdata  combinational HI/LO reads with write-through
//   commit_cnt          count of committed non-r0 GPR writes (wraps)
module regfile_hilo #(
   parameter int WB_TO_RF_WD = 38,
   parameter int NREG        = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
   input  logic [1:0]             hilo_wb_to_rf_bus,
   input  logic [31:0]            wb_hi_wdata,
   input  logic [31:0]            wb_lo_wdata,
   input  logic                   ex_we,
   input  logic [4:0]             ex_waddr,
   input  logic [31:0]            ex_wdata,
   input  logic                   mem_we,
   input  logic [4:0]             mem_waddr,
   input  logic [31:0]            mem_wdata,
   input  logic [4:0]             raddr1,
   input  logic [4:0]             raddr2,
   output logic [31:0]            rdata1,
   output logic [31:0]            rdata2,
   output logic [31:0]            hi_rdata,
   output logic [31:0]            lo_rdata,
   output logic [31:0]            commit_cnt
);

   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        hi_we;
   logic        lo_we;

   assign wb_we    = wb_to_rf_bus[WB_TO_RF_WD-1];
   assign wb_waddr = wb_to_rf_bus[WB_TO_RF_WD-2:WB_TO_RF_WD-6];
   assign wb_wdata = wb_to_rf_bus[31:0];
   assign hi_we    = hilo_wb_to_rf_bus[1];
   assign lo_we    = hilo_wb_to_rf_bus[0];

   logic [31:0] gpr [NREG];
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            gpr[i] <= 32'd0;
         end
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         commit_cnt <= 32'd0;
      end else begin
         // r0 is never written, so its array entry stays zero from reset.
         if (wb_we && (wb_waddr != 5'd0)) begin
            gpr[wb_waddr] <= wb_wdata;
            commit_cnt    <= commit_cnt + 32'd1;
         end
         if (hi_we) begin
            hi_q <= wb_hi_wdata;
         end
         if (lo_we) begin
            lo_q <= wb_lo_wdata;
         end
      end
   end

   // Youngest producer wins: EX is newer than MEM, MEM newer than WB.
   // The r0 check comes first so forwarded writes to r0 never leak out.
   always_comb begin
      rdata1 = gpr[raddr1];
      if (raddr1 == 5'd0) begin
         rdata1 = 32'd0;
      end else if (ex_we && (ex_waddr == raddr1)) begin
         rdata1 = ex_wdata;
      end else if (mem_we && (mem_waddr == raddr1)) begin
         rdata1 = mem_wdata;
      end else if (wb_we && (wb_waddr == raddr1)) begin
         rdata1 = wb_wdata;
      end
   end

   always_comb begin
      rdata2 = gpr[raddr2];
      if (raddr2 == 5'd0) begin
         rdata2 = 32'd0;
      end else if (ex_we && (ex_waddr == raddr2)) begin
         rdata2 = ex_wdata;
      end else if (mem_we && (mem_waddr == raddr2)) begin
         rdata2 = mem_wdata;
      end else if (wb_we && (wb_waddr == raddr2)) begin
         rdata2 = wb_wdata;
      end
   end

   assign hi_rdata = hi_we ? wb_hi_wdata : hi_q;
   assign lo_rdata = lo_we ? wb_lo_wdata : lo_q;

endmodule

// File: tb/tb_regfile_hilo.sv
// tb/tb_regfile_hilo.sv - self-checking bench for regfile_hilo
module tb_regfile_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic [37:0] wb_to_rf_bus;
   logic [1:0]  hilo_wb_to_rf_bus;
   logic [31:0] wb_hi_wdata, wb_lo_wdata;
   logic        ex_we, mem_we;
   logic [4:0]  ex_waddr, mem_waddr;
   logic [31:0] ex_wdata, mem_wdata;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata, commit_cnt;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [31:0] m_gpr [32];
   logic [31:0] m_hi, m_lo, m_cnt;

   always #5 clk = ~clk;

   regfile_hilo dut (
      .clk(clk), .rst(rst),
      .wb_to_rf_bus(wb_to_rf_bus), .hilo_wb_to_rf_bus(hilo_wb_to_rf_bus),
      .wb_hi_wdata(wb_hi_wdata), .wb_lo_wdata(wb_lo_wdata),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .commit_cnt(commit_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb_to_rf_bus = {we, a, d};
   endtask

   // Expected read from the priority rules: r0, EX, MEM, WB, stored value.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (ex_we && ex_waddr == a) return ex_wdata;
      if (mem_we && mem_waddr == a) return mem_wdata;
      if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] == a) return wb_to_rf_bus[31:0];
      return m_gpr[a];
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".rdata1"}, rdata1, exp_rd(raddr1));
      check({tag, ".rdata2"}, rdata2, exp_rd(raddr2));
      check({tag, ".hi"}, hi_rdata, hilo_wb_to_rf_bus[1] ? wb_hi_wdata : m_hi);
      check({tag, ".lo"}, lo_rdata, hilo_wb_to_rf_bus[0] ? wb_lo_wdata : m_lo);
      check({tag, ".cnt"}, commit_cnt, m_cnt);
   endtask

   // Advance one clock edge and apply the commit rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
         m_hi = 0; m_lo = 0; m_cnt = 0;
      end else begin
         if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] != 5'd0) begin
            m_gpr[wb_to_rf_bus[36:32]] = wb_to_rf_bus[31:0];
            m_cnt = m_cnt + 32'd1;
         end
         if (hilo_wb_to_rf_bus[1]) m_hi = wb_hi_wdata;
         if (hilo_wb_to_rf_bus[0]) m_lo = wb_lo_wdata;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      set_wb(1'b0, 5'd0, 32'd0);
      hilo_wb_to_rf_bus = 2'b00;
      wb_hi_wdata = 0; wb_lo_wdata = 0;
      ex_we = 0; ex_waddr = 0; ex_wdata = 0;
      mem_we = 0; mem_waddr = 0; mem_wdata = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'hx;
      m_hi = 'x; m_lo = 'x; m_cnt = 'x;
      rst = 1'b1;
      idle();
      raddr1 = 5'd5; raddr2 = 5'd0;
      @(negedge clk);

      // 1: reset holds off a presented write
      set_wb(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      check("t1.rst_fwd", rdata1, 32'hDEADBEEF);
      tick();
      rst = 1'b0;
      set_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("t1.r5", rdata1, 32'd0);
      check("t1.cnt", commit_cnt, 32'd0);
      check_all("t1");

      // 2: same-cycle write-through then array read
      set_wb(1'b1, 5'd3, 32'h12345678);
      raddr1 = 5'd3;
      #1;
      check("t2.bypass", rdata1, 32'h12345678);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("t2.array", rdata1, 32'h12345678);
      check("t2.cnt", commit_cnt, 32'd1);

      // 3: r0 ignores WB and EX
      set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
      ex_we = 1; ex_waddr = 0; ex_wdata = 32'h55555555;
      raddr1 = 5'd0;
      #1;
      check("t3.r0_comb", rdata1, 32'd0);
      tick();
      idle();
      #1;
      check("t3.r0", rdata1, 32'd0);
      check("t3.cnt", commit_cnt, 32'd1);

      // 4: forwarding priority on r7
      set_wb(1'b1, 5'd7, 32'hD);
      tick();
      ex_we = 1; ex_waddr = 7; ex_wdata = 32'hA;
      mem_we = 1; mem_waddr = 7; mem_wdata = 32'hB;
      set_wb(1'b1, 5'd7, 32'hC);
      raddr1 = 5'd7; raddr2 = 5'd7;
      #1;
      check("t4.ex", rdata1, 32'hA);
      check("t4.same_port", rdata2, 32'hA);
      ex_we = 0;
      #1;
      check("t4.mem", rdata1, 32'hB);
      mem_we = 0;
      #1;
      check("t4.wb", rdata1, 32'hC);
      set_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("t4.array", rdata1, 32'hD);
      idle();

      // 5: HI/LO independent enables
      hilo_wb_to_rf_bus = 2'b11; wb_hi_wdata = 32'h1; wb_lo_wdata = 32'h2;
      #1;
      check("t5.hi0", hi_rdata, 32'h1);
      check("t5.lo0", lo_rdata, 32'h2);
      tick();
      hilo_wb_to_rf_bus = 2'b01; wb_hi_wdata = 32'h99; wb_lo_wdata = 32'h3;
      #1;
      check("t5.hi1", hi_rdata, 32'h1);
      check("t5.lo1", lo_rdata, 32'h3);
      tick();
      idle();
      #1;
      check("t5.hi2", hi_rdata, 32'h1);
      check("t5.lo2", lo_rdata, 32'h3);

      // 6: commit counter wrap
      force dut.commit_cnt = 32'hFFFFFFFF;
      #1;
      release dut.commit_cnt;
      m_cnt = 32'hFFFFFFFF;
      check("t6.preload", commit_cnt, 32'hFFFFFFFF);
      set_wb(1'b1, 5'd9, 32'h0BADF00D);
      tick();
      idle();
      #1;
      check("t6.wrap", commit_cnt, 32'd0);

      // Randomized traffic on a narrow address range to provoke collisions
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         set_wb($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
         hilo_wb_to_rf_bus = 2'($urandom_range(0, 3));
         wb_hi_wdata = $urandom; wb_lo_wdata = $urandom;
         ex_we = $urandom_range(0, 1); ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
         mem_we = $urandom_range(0, 1); mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
         raddr1 = 5'($urandom_range(0, 7));
         raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
         #1;
         check_all("rnd");
         tick();
      end
      rst = 0;
      idle();
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         #1;
         check_all("final");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
